// File: rtl/ror32_iter_if.sv
// Bus bundle for the iterative rotate-right unit: request side (start/in/num_shifts)
// and result side (out/busy/done), plus the FSM state for observation.
interface ror32_iter_if #(
    parameter int WIDTH = 32
);
    // Handshake: start is taken only while busy is low; once taken, busy stays
    // high until the cycle after the single-cycle done pulse, and out is valid
    // from the done cycle until the next done or clr.
    logic             start;
    logic [WIDTH-1:0] in;
    logic [31:0]      num_shifts;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, in, num_shifts,
        input  out, busy, done, state
    );

    modport slave (
        input  start, in, num_shifts,
        output out, busy, done, state
    );
endinterface

// File: rtl/ror32_iter.sv
// Multi-cycle rotate-right: rotates the captured operand by up to STEP bits per
// clock and pulses done for one cycle with the result held on out.
module ror32_iter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       clr,
    ror32_iter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    // STEP may equal WIDTH, so it needs one bit more than the amount register.
    localparam logic [AMT_W:0] STEP_L = (AMT_W + 1)'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic [AMT_W-1:0] amt;
    logic [AMT_W-1:0] step_amt;
    logic [WIDTH-1:0] rot_val;
    logic             unused_upper;

    // Only num_shifts mod WIDTH matters.
    assign amt          = bus.num_shifts[AMT_W-1:0];
    assign unused_upper = ^bus.num_shifts[31:AMT_W];

    always_comb begin
        step_amt = STEP_L[AMT_W-1:0];
        if ({1'b0, rem_q} < STEP_L) begin
            step_amt = rem_q;
        end
        // step_amt is never 0 in ROT, so the left shift stays below WIDTH.
        rot_val = (sr_q >> step_amt) | (sr_q << (WIDTH - int'(step_amt)));
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rem_d   = rem_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d  = bus.in;
                    rem_d = amt;
                    if (amt == '0) begin
                        state_d = DONE;
                        out_d   = bus.in;
                    end else begin
                        state_d = ROT;
                    end
                end
            end
            ROT: begin
                sr_d  = rot_val;
                rem_d = rem_q - step_amt;
                if (rem_d == '0) begin
                    state_d = DONE;
                    out_d   = rot_val;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            sr_q    <= '0;
            rem_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
        end
    end

    // All outputs decode registered state only.
    assign bus.out   = out_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.state = state_q;

endmodule

// File: tb/tb_ror32_iter.sv
// Bench for ror32_iter: STEP=1 and STEP=4 instances share stimulus; a cycle-count
// model checks every cycle and directed vectors pin timing and result literals.
module tb_ror32_iter;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] opnd;
    logic [31:0] nsh;
    bit          run = 1'b0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    ror32_iter_if #(.WIDTH(W)) b1 ();
    ror32_iter_if #(.WIDTH(W)) b4 ();

    assign b1.start      = start;
    assign b1.in         = opnd;
    assign b1.num_shifts = nsh;
    assign b4.start      = start;
    assign b4.in         = opnd;
    assign b4.num_shifts = nsh;

    ror32_iter #(.WIDTH(W), .STEP(1)) u1 (.clk(clk), .clr(clr), .bus(b1));
    ror32_iter #(.WIDTH(W), .STEP(4)) u4 (.clk(clk), .clr(clr), .bus(b4));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int a);
        int r;
        r = a % W;
        if (r == 0) return x;
        return (x >> r) | (x << (W - r));
    endfunction

    // Model: m_cnt = cycles still to show busy (the last one is the done cycle).
    int          m_cnt[2];
    logic [31:0] m_res[2];
    logic [31:0] m_out[2];
    int          steps[2] = '{1, 4};

    always @(posedge clk) begin
        int a;
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                m_cnt[i] = 0;
                m_out[i] = '0;
            end else if (m_cnt[i] > 0) begin
                m_cnt[i]--;
                if (m_cnt[i] == 1) m_out[i] = m_res[i];
            end else if (start) begin
                a        = int'(nsh % 32);
                m_res[i] = rotr(opnd, a);
                m_cnt[i] = (a + steps[i] - 1) / steps[i] + 1;
                if (m_cnt[i] == 1) m_out[i] = m_res[i];
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("u1_busy", 32'(b1.busy), 32'(m_cnt[0] > 0));
            chk("u1_done", 32'(b1.done), 32'(m_cnt[0] == 1));
            chk("u1_out", b1.out, m_out[0]);
            chk("u4_busy", 32'(b4.busy), 32'(m_cnt[1] > 0));
            chk("u4_done", 32'(b4.done), 32'(m_cnt[1] == 1));
            chk("u4_out", b4.out, m_out[1]);
        end
    end

    // Called at a negedge; start is sampled at the next edge (edge 0) and the
    // task returns at the negedge of cycle 1.
    task automatic do_start(input logic [31:0] a, input logic [31:0] n);
        start = 1'b1;
        opnd  = a;
        nsh   = n;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int which, input int c0, output int c);
        c = c0;
        while (((which == 0) ? !b1.done : !b4.done) && c < 64) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((b1.busy || b4.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    logic [31:0] vec_in[6] = '{32'hCAFEBABE, 32'h80000001, 32'h0F0F00FF, 32'h13579BDF, 32'hFFFF0000, 32'h00000002};
    logic [31:0] vec_n[6]  = '{32'd7, 32'd31, 32'd17, 32'hFFFFFFE3, 32'd3, 32'd64};

    initial begin
        int c;
        clr   = 1'b1;
        start = 1'b0;
        opnd  = '0;
        nsh   = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        run = 1'b1;
        chk("rst_out", b1.out, 32'h0);
        chk("rst_busy", 32'(b1.busy), 32'd0);
        chk("rst_done", 32'(b1.done), 32'd0);
        @(negedge clk);

        do_start(32'h00000001, 32'd1);
        chk("t1_busy_c1", 32'(b1.busy), 32'd1);
        wait_done(0, 1, c);
        chk("t1_done_cycle", 32'(c), 32'd2);
        chk("t1_out", b1.out, 32'h80000000);
        wait_idle();

        do_start(32'h12345678, 32'd4);
        wait_done(0, 1, c);
        chk("t2_done_cycle", 32'(c), 32'd5);
        chk("t2_out", b1.out, 32'h81234567);
        wait_idle();
        do_start(32'h12345678, 32'd36);
        wait_done(0, 1, c);
        chk("t2b_done_cycle", 32'(c), 32'd5);
        chk("t2b_out", b1.out, 32'h81234567);
        wait_idle();

        do_start(32'hDEADBEEF, 32'd32);
        wait_done(0, 1, c);
        chk("t3_done_cycle", 32'(c), 32'd1);
        chk("t3_out", b1.out, 32'hDEADBEEF);
        wait_idle();
        do_start(32'hDEADBEEF, 32'd0);
        wait_done(0, 1, c);
        chk("t3b_done_cycle", 32'(c), 32'd1);
        chk("t3b_out", b1.out, 32'hDEADBEEF);
        wait_idle();

        do_start(32'hA5A5A5A5, 32'd8);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        opnd  = 32'hFFFFFFFF;
        nsh   = 32'd8;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, 4, c);
        chk("t4_done_cycle", 32'(c), 32'd9);
        chk("t4_out", b1.out, 32'hA5A5A5A5);
        start = 1'b1;
        opnd  = 32'h00000001;
        nsh   = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_start_on_done_ignored", 32'(b1.busy), 32'd0);
        do_start(32'h00000003, 32'd1);
        chk("t4_restart_busy", 32'(b1.busy), 32'd1);
        wait_done(0, 1, c);
        chk("t4_restart_cycle", 32'(c), 32'd2);
        chk("t4_restart_out", b1.out, 32'h80000001);
        wait_idle();

        do_start(32'h0000000F, 32'd20);
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t5_clr_busy", 32'(b1.busy), 32'd0);
        chk("t5_clr_out", b1.out, 32'h0);
        chk("t5_clr_state", 32'(b1.state), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_done", 32'(b1.done), 32'd0);
            @(negedge clk);
        end
        do_start(32'h0000000F, 32'd2);
        wait_done(0, 1, c);
        chk("t5_done_cycle", 32'(c), 32'd3);
        chk("t5_out", b1.out, 32'hC0000003);
        wait_idle();

        do_start(32'h12345678, 32'd10);
        wait_done(1, 1, c);
        chk("t6_step4_cycle", 32'(c), 32'd4);
        chk("t6_step4_out", b4.out, 32'h9E048D15);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            do_start(vec_in[i], vec_n[i]);
            opnd = ~vec_in[i];
            nsh  = vec_n[i] + 32'd5;
            wait_idle();
        end

        run = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
